// File: rtl/adc_cap_pkg.sv
// Shared types for the ADC capture gate.
//   cap_state_t : capture sequencer states
//   cap_mode_t  : trigger source selection (encoding matches the 2-bit mode input)
package adc_cap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    CAPTURE,
    DONE
  } cap_state_t;

  typedef enum logic [1:0] {
    MODE_IMM       = 2'd0,
    MODE_SYSREF    = 2'd1,
    MODE_SW        = 2'd2,
    MODE_SW_SYSREF = 2'd3
  } cap_mode_t;

endpackage

// File: rtl/cap_trig_sel.sv
// Trigger selection for the ADC capture gate.
//   clk, rst : clock and synchronous active-high reset
//   armed    : sequencer is waiting for a trigger; triggers are only produced while high
//   sysref   : SYSREF already registered in clk; rising edge detected here
//   sw_trig  : software trigger pulse
//   mode     : trigger source latched at arm
//   trig     : 1-cycle trigger toward the sequencer
module cap_trig_sel
  import adc_cap_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      armed,
  input  logic      sysref,
  input  logic      sw_trig,
  input  cap_mode_t mode,
  output logic      trig
);

  logic sysref_q;
  logic qual_q;
  logic qual_d;
  logic sysref_rise;

  assign sysref_rise = sysref & ~sysref_q;

  // The qualifier only exists while armed, so a stale sw_trig from an earlier
  // sequence can never release a later capture.
  always_comb begin
    qual_d = qual_q;
    if (!armed) begin
      qual_d = 1'b0;
    end else if (sw_trig && (mode == MODE_SW_SYSREF)) begin
      qual_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sysref_q <= 1'b0;
      qual_q   <= 1'b0;
    end else begin
      sysref_q <= sysref;
      qual_q   <= qual_d;
    end
  end

  // Mode 3 looks at the registered qualifier, so a rise in the same cycle as
  // sw_trig does not fire.
  always_comb begin
    trig = 1'b0;
    if (armed) begin
      unique case (mode)
        MODE_IMM:       trig = 1'b1;
        MODE_SYSREF:    trig = sysref_rise;
        MODE_SW:        trig = sw_trig;
        MODE_SW_SYSREF: trig = qual_q & sysref_rise;
      endcase
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Capture gate between NCHAN ADC AXI4-Stream outputs and the PS readout buffers.
// After arm and a selectable trigger, waits trig_dly cycles, then forwards
// cap_len+1 aligned beats per enabled channel with tlast on the final beat.
//   aclk, arst             : clock, synchronous active-high reset
//   s_axis_*               : ADC input streams (tready tied high, ADCs never stall)
//   m_axis_*               : registered output streams to the readout buffers
//   sysref, arm, sw_trig   : trigger/control pulses
//   mode, chan_en, cap_len, trig_dly : configuration, sampled on an accepted arm
//   busy, done, overflow, beat_count : status
module adc_capture_ctrl
  import adc_cap_pkg::*;
#(
  parameter int unsigned NCHAN     = 4,
  parameter int unsigned ADC_WIDTH = 128,
  parameter int unsigned LEN_BITS  = 14,
  parameter int unsigned DLY_BITS  = 16
) (
  input  logic                       aclk,
  input  logic                       arst,
  input  logic [NCHAN*ADC_WIDTH-1:0] s_axis_tdata,
  input  logic [NCHAN-1:0]           s_axis_tvalid,
  output logic [NCHAN-1:0]           s_axis_tready,
  output logic [NCHAN*ADC_WIDTH-1:0] m_axis_tdata,
  output logic [NCHAN-1:0]           m_axis_tvalid,
  output logic [NCHAN-1:0]           m_axis_tlast,
  input  logic [NCHAN-1:0]           m_axis_tready,
  input  logic                       sysref,
  input  logic                       arm,
  input  logic                       sw_trig,
  input  logic [1:0]                 mode,
  input  logic [NCHAN-1:0]           chan_en,
  input  logic [LEN_BITS-1:0]        cap_len,
  input  logic [DLY_BITS-1:0]        trig_dly,
  output logic                       busy,
  output logic                       done,
  output logic                       overflow,
  output logic [LEN_BITS:0]          beat_count
);

  cap_state_t          state_q, state_d;
  cap_mode_t           mode_q;
  logic [NCHAN-1:0]    chan_en_q;
  logic [LEN_BITS-1:0] cap_len_q;
  logic [DLY_BITS-1:0] trig_dly_q;
  logic [DLY_BITS-1:0] dly_cnt_q, dly_cnt_d;
  logic [LEN_BITS:0]   beat_cnt_q, beat_cnt_d;
  logic                overflow_q, overflow_d;
  logic                done_q, done_d;

  logic                armed;
  logic                trig;
  logic                arm_ok;
  logic                beat_ok;
  logic                cap_beat;
  logic                last_beat;
  logic [LEN_BITS:0]   cap_total;

  assign s_axis_tready = '1;

  assign armed     = (state_q == ARMED);
  assign arm_ok    = (state_q == IDLE) && arm;
  // Disabled channels never hold back the aligned beat.
  assign beat_ok   = &(s_axis_tvalid | ~chan_en_q);
  assign cap_beat  = (state_q == CAPTURE) && beat_ok;
  // One wider than cap_len so the maximum length does not wrap.
  assign cap_total = {1'b0, cap_len_q} + 1'b1;
  assign last_beat = cap_beat && ((beat_cnt_q + 1'b1) == cap_total);

  cap_trig_sel u_trig_sel (
    .clk     (aclk),
    .rst     (arst),
    .armed   (armed),
    .sysref  (sysref),
    .sw_trig (sw_trig),
    .mode    (mode_q),
    .trig    (trig)
  );

  always_comb begin
    state_d    = state_q;
    dly_cnt_d  = dly_cnt_q;
    beat_cnt_d = beat_cnt_q;
    done_d     = 1'b0;
    // Beats are never held: any refused beat is lost and flagged.
    overflow_d = overflow_q | (|(m_axis_tvalid & ~m_axis_tready));

    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d    = ARMED;
          beat_cnt_d = '0;
          overflow_d = 1'b0;
        end
      end
      ARMED: begin
        if (trig) begin
          if (trig_dly_q == '0) begin
            state_d = CAPTURE;
          end else begin
            state_d   = DELAY;
            dly_cnt_d = {{(DLY_BITS-1){1'b0}}, 1'b1};
          end
        end
      end
      DELAY: begin
        if (dly_cnt_q == trig_dly_q) begin
          state_d = CAPTURE;
        end else begin
          dly_cnt_d = dly_cnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        if (cap_beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (last_beat) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q    <= IDLE;
      dly_cnt_q  <= '0;
      beat_cnt_q <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
      mode_q     <= MODE_IMM;
      chan_en_q  <= '0;
      cap_len_q  <= '0;
      trig_dly_q <= '0;
    end else begin
      state_q    <= state_d;
      dly_cnt_q  <= dly_cnt_d;
      beat_cnt_q <= beat_cnt_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
      if (arm_ok) begin
        mode_q     <= cap_mode_t'(mode);
        chan_en_q  <= chan_en;
        cap_len_q  <= cap_len;
        trig_dly_q <= trig_dly;
      end
    end
  end

  for (genvar i = 0; i < NCHAN; i++) begin : g_chan
    logic                 valid_q;
    logic                 last_q;
    logic [ADC_WIDTH-1:0] data_q;

    always_ff @(posedge aclk) begin
      if (arst) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= cap_beat & chan_en_q[i];
        last_q  <= last_beat & chan_en_q[i];
        if (cap_beat && chan_en_q[i]) begin
          data_q <= s_axis_tdata[i*ADC_WIDTH +: ADC_WIDTH];
        end
      end
    end

    assign m_axis_tvalid[i]                         = valid_q;
    assign m_axis_tlast[i]                          = last_q;
    assign m_axis_tdata[i*ADC_WIDTH +: ADC_WIDTH]   = data_q;
  end

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign beat_count = beat_cnt_q;

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Bench for adc_capture_ctrl. Each ADC beat carries {channel id, cycle stamp},
// so the stamp on an output beat shows which input cycle was forwarded.
module tb_adc_capture_ctrl;

  localparam int NCH   = 4;
  localparam int ADC_W = 128;
  localparam int LEN_B = 14;
  localparam int DLY_B = 16;

  logic                     aclk = 1'b0;
  logic                     arst;
  logic [NCH*ADC_W-1:0]     s_axis_tdata;
  logic [NCH-1:0]           s_axis_tvalid;
  logic [NCH-1:0]           s_axis_tready;
  logic [NCH*ADC_W-1:0]     m_axis_tdata;
  logic [NCH-1:0]           m_axis_tvalid;
  logic [NCH-1:0]           m_axis_tlast;
  logic [NCH-1:0]           m_axis_tready;
  logic                     sysref;
  logic                     arm;
  logic                     sw_trig;
  logic [1:0]               mode;
  logic [NCH-1:0]           chan_en;
  logic [LEN_B-1:0]         cap_len;
  logic [DLY_B-1:0]         trig_dly;
  logic                     busy;
  logic                     done;
  logic                     overflow;
  logic [LEN_B:0]           beat_count;

  int cyc = 0;

  always #5 aclk = ~aclk;

  for (genvar g = 0; g < NCH; g++) begin : g_src
    assign s_axis_tdata[g*ADC_W +: ADC_W] = {{(ADC_W-64){1'b0}}, 32'(g), 32'(cyc)};
  end

  adc_capture_ctrl #(
    .NCHAN     (NCH),
    .ADC_WIDTH (ADC_W),
    .LEN_BITS  (LEN_B),
    .DLY_BITS  (DLY_B)
  ) dut (
    .aclk          (aclk),
    .arst          (arst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .sysref        (sysref),
    .arm           (arm),
    .sw_trig       (sw_trig),
    .mode          (mode),
    .chan_en       (chan_en),
    .cap_len       (cap_len),
    .trig_dly      (trig_dly),
    .busy          (busy),
    .done          (done),
    .overflow      (overflow),
    .beat_count    (beat_count)
  );

  typedef struct {
    logic [1:0] mode;
    int         dly;
    int         len;
    logic [3:0] en;
    int         sw1, sw2, sr1, sr2;  // pulse offsets from the arm cycle, -1 = none
    int         first;               // expected first forwarded stamp, offset from arm
    int         beats;
  } vec_t;

  vec_t vecs[8];

  int n_tests = 0;
  int n_fail  = 0;
  int arm_cyc;

  int nbeats[NCH], first_stamp[NCH], last_stamp[NCH], tlast_cnt[NCH], tlast_idx[NCH];
  int done_cnt, done_cyc, tlast_cyc, busy_first, data_err;

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    for (int i = 0; i < NCH; i++) begin
      nbeats[i] = 0; first_stamp[i] = -1; last_stamp[i] = -1;
      tlast_cnt[i] = 0; tlast_idx[i] = 0;
    end
    done_cnt = 0; done_cyc = -1; tlast_cyc = -1; busy_first = -1; data_err = 0;
  endtask

  task automatic sample();
    int stamp, tag;
    for (int i = 0; i < NCH; i++) begin
      if (m_axis_tvalid[i]) begin
        stamp = int'(m_axis_tdata[i*ADC_W +: 32]);
        tag   = int'(m_axis_tdata[i*ADC_W+32 +: 32]);
        if (tag != i) data_err++;
        if (nbeats[i] == 0) first_stamp[i] = stamp;
        last_stamp[i] = stamp;
        nbeats[i]++;
        if (m_axis_tlast[i]) begin
          tlast_cnt[i]++;
          tlast_idx[i] = nbeats[i];
          tlast_cyc    = cyc;
        end
      end else if (m_axis_tlast[i]) begin
        data_err++;
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy && busy_first < 0) busy_first = cyc;
  endtask

  // Sample in the middle of the current cycle, then step to #1 after the next edge.
  task automatic tick();
    @(negedge aclk);
    sample();
    @(posedge aclk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_arm(input logic [1:0] m, input logic [3:0] en, input int len, input int dly);
    mode = m; chan_en = en; cap_len = LEN_B'(len); trig_dly = DLY_B'(dly);
    arm = 1'b1;
    arm_cyc = cyc;
    tick();
    arm = 1'b0;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string p;
    p = $sformatf("v%0d", idx);
    clear_mon();
    mode = v.mode; chan_en = v.en; cap_len = LEN_B'(v.len); trig_dly = DLY_B'(v.dly);
    arm = 1'b1;
    arm_cyc = cyc;
    sysref  = (v.sr1 == 0) || (v.sr2 == 0);
    sw_trig = (v.sw1 == 0) || (v.sw2 == 0);
    for (int k = 1; k <= 150; k++) begin
      tick();
      arm     = 1'b0;
      sysref  = (v.sr1 == k) || (v.sr2 == k);
      sw_trig = (v.sw1 == k) || (v.sw2 == k);
    end
    sysref = 1'b0; sw_trig = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      check($sformatf("%s ch%0d beats", p, i), nbeats[i], v.en[i] ? v.beats : 0);
      check($sformatf("%s ch%0d tlast count", p, i), tlast_cnt[i], v.en[i] ? 1 : 0);
      if (v.en[i]) begin
        check($sformatf("%s ch%0d first stamp", p, i), first_stamp[i], arm_cyc + v.first);
        check($sformatf("%s ch%0d span", p, i), last_stamp[i] - first_stamp[i], v.beats - 1);
        check($sformatf("%s ch%0d tlast index", p, i), tlast_idx[i], v.beats);
      end
    end
    check({p, " busy after arm"}, busy_first, arm_cyc + 1);
    check({p, " done pulses"}, done_cnt, 1);
    check({p, " done after tlast"}, done_cyc, tlast_cyc + 1);
    check({p, " beat_count"}, beat_count, v.beats);
    check({p, " busy at end"}, busy, 0);
    check({p, " data tags"}, data_err, 0);
  endtask

  initial begin
    //           mode dly len en    sw1 sw2 sr1 sr2 first beats
    vecs[0] = '{2'd0, 0, 7,  4'hF, -1, -1, -1, -1, 2,  8};
    vecs[1] = '{2'd0, 3, 2,  4'hF, -1, -1, -1, -1, 5,  3};
    vecs[2] = '{2'd1, 5, 3,  4'hF, -1, -1, 20, -1, 26, 4};
    vecs[3] = '{2'd2, 0, 0,  4'hF, 4,  -1, -1, -1, 5,  1};
    vecs[4] = '{2'd2, 1, 4,  4'h3, 0,  3,  -1, -1, 5,  5};
    vecs[5] = '{2'd3, 0, 3,  4'hF, 10, -1, 10, 40, 41, 4};
    vecs[6] = '{2'd1, 2, 1,  4'h8, -1, -1, 0,  8,  11, 2};
    vecs[7] = '{2'd3, 0, 2,  4'hF, 5,  -1, 2,  9,  10, 3};

    arst = 1'b1; arm = 1'b0; sw_trig = 1'b0; sysref = 1'b0;
    mode = '0; chan_en = '0; cap_len = '0; trig_dly = '0;
    s_axis_tvalid = '1; m_axis_tready = '1;
    clear_mon();
    @(posedge aclk);
    #1;
    run(3);

    check("reset tvalid", m_axis_tvalid, 0);
    check("reset tlast", m_axis_tlast, 0);
    check("reset tdata nonzero", longint'(m_axis_tdata != '0), 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset overflow", overflow, 0);
    check("reset beat_count", beat_count, 0);
    check("reset s_tready", s_axis_tready, 4'hF);
    arst = 1'b0;
    run(2);
    check("idle busy", busy, 0);

    for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);

    // Gaps: channels 0/2 enabled, channel 1 invalid but masked, channel 2 stalls 3 cycles.
    clear_mon();
    s_axis_tvalid = 4'b1101;
    do_arm(2'd0, 4'b0101, 5, 0);
    run(3);
    s_axis_tvalid[2] = 1'b0;
    run(3);
    s_axis_tvalid[2] = 1'b1;
    run(15);
    s_axis_tvalid = '1;
    check("gap ch0 beats", nbeats[0], 6);
    check("gap ch2 beats", nbeats[2], 6);
    check("gap ch1 beats", nbeats[1], 0);
    check("gap ch3 beats", nbeats[3], 0);
    check("gap ch2 first", first_stamp[2], arm_cyc + 2);
    check("gap ch2 last", last_stamp[2], arm_cyc + 10);
    check("gap ch2 tlast index", tlast_idx[2], 6);
    check("gap beat_count", beat_count, 6);

    // Overflow: channel 3 refuses one beat.
    clear_mon();
    do_arm(2'd0, 4'hF, 7, 0);
    run(3);
    m_axis_tready[3] = 1'b0;
    check("ovf before refusal", overflow, 0);
    tick();
    m_axis_tready[3] = 1'b1;
    check("ovf set", overflow, 1);
    run(20);
    check("ovf sticky", overflow, 1);
    for (int i = 0; i < NCH; i++) check($sformatf("ovf ch%0d beats", i), nbeats[i], 8);
    check("ovf done", done_cnt, 1);
    clear_mon();
    do_arm(2'd0, 4'hF, 1, 0);
    check("ovf cleared by arm", overflow, 0);
    run(20);
    check("ovf rearm done", done_cnt, 1);

    // Reset in the middle of a 16-beat capture, right after the 4th output beat.
    clear_mon();
    do_arm(2'd0, 4'hF, 15, 0);
    run(5);
    arst = 1'b1;
    tick();
    check("arst beats before", nbeats[0], 4);
    check("arst tvalid", m_axis_tvalid, 0);
    check("arst tlast", m_axis_tlast, 0);
    check("arst tdata nonzero", longint'(m_axis_tdata != '0), 0);
    check("arst busy", busy, 0);
    check("arst beat_count", beat_count, 0);
    arst = 1'b0;
    run(30);
    check("arst no tlast", tlast_cnt[0] + tlast_cnt[1] + tlast_cnt[2] + tlast_cnt[3], 0);
    check("arst no done", done_cnt, 0);
    check("arst no more beats", nbeats[0], 4);

    // Second arm while busy is ignored.
    clear_mon();
    do_arm(2'd0, 4'hF, 3, 0);
    tick();
    mode = 2'd2; cap_len = 14'd10; chan_en = 4'h1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    run(20);
    check("rearm ch3 beats", nbeats[3], 4);
    check("rearm ch0 first", first_stamp[0], arm_cyc + 2);
    check("rearm beat_count", beat_count, 4);
    check("rearm done", done_cnt, 1);
    check("rearm busy", busy, 0);

    // Maximum length: 2^LEN_B beats, no counter wrap.
    clear_mon();
    do_arm(2'd0, 4'hF, (1 << LEN_B) - 1, 0);
    for (int k = 0; k < (1 << LEN_B) + 100 && done_cnt == 0; k++) tick();
    check("max done", done_cnt, 1);
    check("max ch1 beats", nbeats[1], 1 << LEN_B);
    check("max ch1 tlast index", tlast_idx[1], 1 << LEN_B);
    check("max span", last_stamp[1] - first_stamp[1], (1 << LEN_B) - 1);
    check("max beat_count", beat_count, 1 << LEN_B);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
